// File: rtl/ddr2_line_master.sv
// Cache-line burst initiator for the DDR2 controller local (Avalon) port.
// Turns one whole-line read/write request into a single LINE_BEATS x 256-bit burst.
module ddr2_line_master #(
   parameter int unsigned LINE_BEATS = 2,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic                      phy_clk,
   input  logic                      reset_phy_clk,

   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [24:0]               req_addr,
   input  logic [256*LINE_BEATS-1:0] req_wdata,
   input  logic [32*LINE_BEATS-1:0]  req_be,

   output logic                      rsp_valid,
   output logic                      rsp_write,
   output logic [256*LINE_BEATS-1:0] rsp_rdata,
   output logic                      rsp_error,
   output logic                      fault,
   output logic                      stray_beat,

   input  logic                      local_init_done,
   input  logic                      local_ready,
   input  logic [255:0]              local_rdata,
   input  logic                      local_rdata_valid,
   input  logic                      local_rdata_error,
   input  logic                      local_wdata_req,
   output logic [24:0]               local_address,
   output logic                      local_read_req,
   output logic                      local_write_req,
   output logic                      local_burstbegin,
   output logic [6:0]                local_size,
   output logic [255:0]              local_wdata,
   output logic [31:0]               local_be,
   output logic                      local_autopch_req,
   output logic                      local_multicast_req,
   output logic                      local_refresh_req,
   output logic                      local_refresh_chip,
   output logic                      local_self_rfsh_req
);

   localparam int unsigned LINE_W   = 256 * LINE_BEATS;
   localparam int unsigned BE_W     = 32 * LINE_BEATS;
   localparam int unsigned CNT_W    = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
   localparam int unsigned TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   localparam logic [24:0]      ADDR_MASK = ~25'(LINE_BEATS - 1);
   localparam logic [6:0]       BURST_SZ  = 7'(LINE_BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

   typedef enum logic [2:0] {
      IDLE, WR_BURST, RD_CMD, RD_DATA, RESP, FAULT
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [TMO_W-1:0]  tmo;
   logic              err_acc;
   logic [LINE_W-1:0] wline;
   logic [BE_W-1:0]   bline;
   logic [LINE_W-1:0] rline;
   logic [LINE_W-1:0] rline_upd;
   logic              unused_wdata_req;

   // Avalon mode: the controller's wdata_req handshake is not used.
   assign unused_wdata_req = local_wdata_req;

   assign local_autopch_req   = 1'b0;
   assign local_multicast_req = 1'b0;
   assign local_refresh_req   = 1'b0;
   assign local_refresh_chip  = 1'b0;
   assign local_self_rfsh_req = 1'b0;

   assign cnt_nxt = cnt + CNT_W'(1);

   // Read line with the incoming beat merged into slot cnt.
   always_comb begin
      rline_upd = rline;
      rline_upd[int'(cnt)*256 +: 256] = local_rdata;
   end

   always_ff @(posedge phy_clk) begin
      if (reset_phy_clk) begin
         state            <= IDLE;
         cnt              <= '0;
         tmo              <= '0;
         err_acc          <= 1'b0;
         wline            <= '0;
         bline            <= '0;
         rline            <= '0;
         req_ready        <= 1'b0;
         rsp_valid        <= 1'b0;
         rsp_write        <= 1'b0;
         rsp_rdata        <= '0;
         rsp_error        <= 1'b0;
         fault            <= 1'b0;
         stray_beat       <= 1'b0;
         local_address    <= '0;
         local_read_req   <= 1'b0;
         local_write_req  <= 1'b0;
         local_burstbegin <= 1'b0;
         local_size       <= '0;
         local_wdata      <= '0;
         local_be         <= '0;
      end else begin
         rsp_valid        <= 1'b0;
         local_burstbegin <= 1'b0;

         // Read data outside the data phase belongs to no request; drop it.
         if (local_rdata_valid && (state != RD_DATA))
            stray_beat <= 1'b1;

         case (state)
            IDLE: begin
               req_ready <= local_init_done && !fault;
               if (req_valid && req_ready) begin
                  req_ready        <= 1'b0;
                  wline            <= req_wdata;
                  bline            <= req_be;
                  cnt              <= '0;
                  tmo              <= '0;
                  err_acc          <= 1'b0;
                  local_address    <= req_addr & ADDR_MASK;
                  local_size       <= BURST_SZ;
                  local_burstbegin <= 1'b1;
                  if (req_write) begin
                     state           <= WR_BURST;
                     local_write_req <= 1'b1;
                     local_wdata     <= req_wdata[255:0];
                     local_be        <= req_be[31:0];
                  end else begin
                     state          <= RD_CMD;
                     local_read_req <= 1'b1;
                  end
               end
            end

            WR_BURST: begin
               if (local_ready) begin
                  if (cnt == LAST_BEAT) begin
                     state           <= RESP;
                     local_write_req <= 1'b0;
                     local_address   <= '0;
                     local_size      <= '0;
                     local_wdata     <= '0;
                     local_be        <= '0;
                     rsp_valid       <= 1'b1;
                     rsp_write       <= 1'b1;
                     rsp_error       <= err_acc;
                  end else begin
                     cnt         <= cnt_nxt;
                     local_wdata <= wline[int'(cnt_nxt)*256 +: 256];
                     local_be    <= bline[int'(cnt_nxt)*32 +: 32];
                  end
               end
            end

            RD_CMD: begin
               if (local_ready) begin
                  state          <= RD_DATA;
                  local_read_req <= 1'b0;
                  local_address  <= '0;
                  local_size     <= '0;
               end
            end

            RD_DATA: begin
               if (local_rdata_valid) begin
                  rline   <= rline_upd;
                  cnt     <= cnt_nxt;
                  tmo     <= '0;
                  err_acc <= err_acc | local_rdata_error;
                  if (cnt == LAST_BEAT) begin
                     state     <= RESP;
                     rsp_rdata <= rline_upd;
                     rsp_valid <= 1'b1;
                     rsp_write <= 1'b0;
                     rsp_error <= err_acc | local_rdata_error;
                  end
               end else if (TIMEOUT != 0) begin
                  if (tmo == TMO_W'(TMO_LAST)) begin
                     state     <= FAULT;
                     fault     <= 1'b1;
                     rsp_valid <= 1'b1;
                     rsp_write <= 1'b0;
                     rsp_error <= 1'b1;
                  end else begin
                     tmo <= tmo + TMO_W'(1);
                  end
               end
            end

            RESP: begin
               state     <= IDLE;
               req_ready <= local_init_done && !fault;
            end

            FAULT: begin
               // Terminal until reset; the request side stays closed.
               req_ready <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr2_line_master.sv
// Directed self-checking bench for ddr2_line_master (LINE_BEATS=2, TIMEOUT=8).
module tb_ddr2_line_master;

   localparam int unsigned LB = 2;

   logic            phy_clk = 1'b0;
   logic            reset_phy_clk = 1'b1;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic            req_write = 1'b0;
   logic [24:0]     req_addr = '0;
   logic [511:0]    req_wdata = '0;
   logic [63:0]     req_be = '0;
   logic            rsp_valid;
   logic            rsp_write;
   logic [511:0]    rsp_rdata;
   logic            rsp_error;
   logic            fault;
   logic            stray_beat;
   logic            local_init_done = 1'b1;
   logic            local_ready = 1'b1;
   logic [255:0]    local_rdata = '0;
   logic            local_rdata_valid = 1'b0;
   logic            local_rdata_error = 1'b0;
   logic            local_wdata_req = 1'b0;
   logic [24:0]     local_address;
   logic            local_read_req;
   logic            local_write_req;
   logic            local_burstbegin;
   logic [6:0]      local_size;
   logic [255:0]    local_wdata;
   logic [31:0]     local_be;
   logic            local_autopch_req;
   logic            local_multicast_req;
   logic            local_refresh_req;
   logic            local_refresh_chip;
   logic            local_self_rfsh_req;

   int checks = 0;
   int errors = 0;
   int bb_cnt = 0;
   int wb_cnt = 0;

   ddr2_line_master #(.LINE_BEATS(LB), .TIMEOUT(8)) dut (
      .phy_clk(phy_clk), .reset_phy_clk(reset_phy_clk),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .fault(fault), .stray_beat(stray_beat),
      .local_init_done(local_init_done), .local_ready(local_ready),
      .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
      .local_rdata_error(local_rdata_error), .local_wdata_req(local_wdata_req),
      .local_address(local_address), .local_read_req(local_read_req),
      .local_write_req(local_write_req), .local_burstbegin(local_burstbegin),
      .local_size(local_size), .local_wdata(local_wdata), .local_be(local_be),
      .local_autopch_req(local_autopch_req), .local_multicast_req(local_multicast_req),
      .local_refresh_req(local_refresh_req), .local_refresh_chip(local_refresh_chip),
      .local_self_rfsh_req(local_self_rfsh_req)
   );

   always #5 phy_clk = ~phy_clk;

   // Count burstbegin pulses and retired write beats, sampled mid-cycle.
   always @(negedge phy_clk) begin
      if (!reset_phy_clk) begin
         if (local_burstbegin) bb_cnt++;
         if (local_write_req && local_ready) wb_cnt++;
      end
   end

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge phy_clk);
      #1;
   endtask

   task automatic do_reset();
      reset_phy_clk     = 1'b1;
      req_valid         = 1'b0;
      local_rdata_valid = 1'b0;
      local_ready       = 1'b1;
      local_init_done   = 1'b1;
      tick();
      tick();
      reset_phy_clk = 1'b0;
      tick();
   endtask

   task automatic wait_ready(input string tag);
      for (int n = 0; n < 20 && !req_ready; n++) tick();
      check(tag, 512'(req_ready), 512'(1));
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_rdata"}, rsp_rdata, '0);
      check({tag, "_wdata"}, 512'(local_wdata), '0);
      check({tag, "_ctl"}, 512'({local_address, local_read_req, local_write_req,
            local_burstbegin, local_size, local_be, rsp_valid, rsp_write, rsp_error,
            fault, stray_beat, local_autopch_req, local_multicast_req,
            local_refresh_req, local_refresh_chip, local_self_rfsh_req}), '0);
   endtask

   // Read line: command stalled for 'stall' cycles, 'gap' idle cycles between beats.
   task automatic run_read(input string tag, input logic [24:0] addr, input int stall,
                           input int gap, input logic [255:0] d0, input logic [255:0] d1,
                           input logic e0, input logic e1);
      wait_ready({tag, "_rdy"});
      req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
      local_ready = (stall == 0);
      tick();
      req_valid = 1'b0;
      check({tag, "_cmd"}, 512'({local_read_req, local_write_req, local_burstbegin,
            local_size, local_address}), 512'({3'b101, 7'd2, addr & ~25'd1}));
      for (int s = 1; s <= stall; s++) begin
         tick();
         check({tag, "_stall"}, 512'({local_read_req, local_burstbegin, local_address}),
               512'({2'b10, addr & ~25'd1}));
         local_ready = (s == stall);
      end
      tick();
      check({tag, "_cmd_done"}, 512'(local_read_req), 512'(0));
      local_ready = 1'b1;
      local_rdata_valid = 1'b1; local_rdata = d0; local_rdata_error = e0;
      tick();
      for (int g = 0; g < gap; g++) begin
         local_rdata_valid = 1'b0; local_rdata_error = 1'b0;
         check({tag, "_gap"}, 512'(rsp_valid), 512'(0));
         tick();
      end
      local_rdata_valid = 1'b1; local_rdata = d1; local_rdata_error = e1;
      tick();
      local_rdata_valid = 1'b0; local_rdata_error = 1'b0;
      check({tag, "_rsp"}, 512'({rsp_valid, rsp_write, rsp_error, req_ready}),
            512'({2'b10, e0 | e1, 1'b0}));
      check({tag, "_data"}, rsp_rdata, {d1, d0});
      tick();
      check({tag, "_after"}, 512'({rsp_valid, req_ready}), 512'(2'b01));
   endtask

   localparam logic [255:0] W0 = {8{32'hA0A0_0001}};
   localparam logic [255:0] W1 = {8{32'hB1B1_0002}};
   localparam logic [31:0]  E0 = 32'hFFFF_000F;
   localparam logic [31:0]  E1 = 32'h0F0F_F0F0;
   localparam logic [255:0] DA = {64{4'hA}};
   localparam logic [255:0] D5 = {64{4'h5}};

   initial begin
      int bb0;
      int wb0;

      // Reset values
      tick();
      tick();
      check_reset_outs("reset");
      check("reset_ready", 512'(req_ready), 512'(0));
      reset_phy_clk = 1'b0;
      tick();
      check("ready_after_reset", 512'(req_ready), 512'(1));

      // Write, ready always high: beats at T+1, T+2, response at T+3
      bb0 = bb_cnt; wb0 = wb_cnt;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 25'h0000123;
      req_wdata = {W1, W0}; req_be = {E1, E0};
      tick();
      req_valid = 1'b0; req_wdata = '0; req_be = '0;
      check("wr_beat0_ctl", 512'({local_write_req, local_read_req, local_burstbegin,
            local_size, local_address}), 512'({3'b101, 7'd2, 25'h0000122}));
      check("wr_beat0_data", 512'({local_be, local_wdata}), 512'({E0, W0}));
      tick();
      check("wr_beat1_ctl", 512'({local_write_req, local_burstbegin}), 512'(2'b10));
      check("wr_beat1_data", 512'({local_be, local_wdata}), 512'({E1, W1}));
      tick();
      check("wr_rsp", 512'({rsp_valid, rsp_write, rsp_error, local_write_req, req_ready}),
            512'(5'b11000));
      tick();
      check("wr_rsp_end", 512'({rsp_valid, req_ready}), 512'(2'b01));
      check("wr_counts", 512'({32'(bb_cnt - bb0), 32'(wb_cnt - wb0)}), 512'({32'd1, 32'd2}));

      // Write with beat 1 stalled for 3 cycles
      bb0 = bb_cnt; wb0 = wb_cnt;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 25'h0000040;
      req_wdata = {W0, W1}; req_be = {E0, E1};
      tick();
      req_valid = 1'b0;
      check("st_beat0", 512'({local_be, local_wdata}), 512'({E1, W1}));
      tick();
      local_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         check("st_beat1_hold", 512'({local_write_req, local_burstbegin, local_address,
               local_be, local_wdata}), 512'({2'b10, 25'h0000040, E0, W0}));
         tick();
      end
      local_ready = 1'b1;
      check("st_beat1_last", 512'({local_write_req, local_be, local_wdata}),
            512'({1'b1, E0, W0}));
      tick();
      check("st_rsp", 512'({rsp_valid, rsp_write}), 512'(2'b11));
      check("st_counts", 512'({32'(bb_cnt - bb0), 32'(wb_cnt - wb0)}), 512'({32'd1, 32'd2}));
      tick();

      // Reads: stalled command with gapped data, error beat, clean follow-up
      run_read("rd_gap", 25'h0000041, 2, 4, DA, D5, 1'b0, 1'b0);
      run_read("rd_err", 25'h0000100, 0, 0, D5, DA, 1'b1, 1'b0);
      run_read("rd_clean", 25'h0000202, 0, 1, W0, W1, 1'b0, 1'b0);
      check("no_stray", 512'(stray_beat), 512'(0));

      // Timeout: only one beat returned
      wait_ready("tmo_rdy");
      req_valid = 1'b1; req_write = 1'b0; req_addr = 25'h0000300;
      tick();
      req_valid = 1'b0;
      tick();
      local_rdata_valid = 1'b1; local_rdata = DA;
      tick();
      local_rdata_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("tmo_before", 512'({rsp_valid, fault}), 512'(0));
      tick();
      check("tmo_fault", 512'({rsp_valid, rsp_error, rsp_write, fault, req_ready}),
            512'(5'b11010));
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("tmo_blocked", 512'({rsp_valid, fault, req_ready, local_read_req,
               local_write_req}), 512'(5'b01000));
      end
      req_valid = 1'b0;
      do_reset();
      check("tmo_cleared", 512'({fault, req_ready}), 512'(2'b01));

      // Stray beat in IDLE
      local_rdata_valid = 1'b1;
      tick();
      local_rdata_valid = 1'b0;
      check("stray_idle", 512'({stray_beat, req_ready, rsp_valid}), 512'(3'b110));

      // init_done low blocks accepts
      local_init_done = 1'b0;
      tick();
      tick();
      req_valid = 1'b1; req_write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("init_blocked", 512'({req_ready, local_write_req, local_read_req}), 512'(0));
      end
      req_valid = 1'b0;
      local_init_done = 1'b1;
      tick();
      tick();
      check("init_back", 512'(req_ready), 512'(1));

      // Reset mid-write
      req_valid = 1'b1; req_write = 1'b1; req_addr = 25'h0000010; req_wdata = {W1, W0};
      local_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      check("mid_wr_active", 512'(local_write_req), 512'(1));
      reset_phy_clk = 1'b1;
      tick();
      check_reset_outs("mid_wr_reset");
      reset_phy_clk = 1'b0;
      local_ready = 1'b1;
      tick();
      check("mid_wr_ready", 512'({req_ready, local_write_req, rsp_valid}), 512'(3'b100));

      // Reset mid-read: late beats are stray
      req_valid = 1'b1; req_write = 1'b0; req_addr = 25'h0000020;
      tick();
      req_valid = 1'b0;
      tick();
      reset_phy_clk = 1'b1;
      tick();
      reset_phy_clk = 1'b0;
      local_rdata_valid = 1'b1; local_rdata = D5;
      tick();
      local_rdata_valid = 1'b0;
      check("late_beat_stray", 512'({stray_beat, rsp_valid}), 512'(2'b10));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
